// File: rtl/dot3_pkg.sv
// Shared types, FP32 field constants and the negative-clamp helper for the dot3 operand feeder.
package dot3_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_CALC = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam int          FP32_SIGN_BIT = 31;
    localparam int          FP32_EXP_MSB  = 30;
    localparam int          FP32_EXP_LSB  = 23;
    localparam int          FP32_MANT_MSB = 22;
    localparam logic [7:0]  FP32_EXP_ONES = 8'hFF;

    // Negative values (including -0.0 and -inf) become +0.0; NaNs keep their payload.
    function automatic logic [31:0] fp32_clamp_neg(input logic [31:0] v);
        logic is_nan;
        is_nan = (v[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ONES) && (v[FP32_MANT_MSB:0] != '0);
        if (v[FP32_SIGN_BIT] && !is_nan)
            return FP32_POS_ZERO;
        return v;
    endfunction

endpackage

// File: rtl/dot3_operand_feeder.sv
// Serialises one {A,B,tag} request into the 3x1 FP32 dot-product engine and returns {result,tag}.
//
// state     | meaning
// IDLE      | waiting for a pending request, an idle engine and a drained output
// STREAM    | presenting A0..A2,B0..B2 one word per dp_data_done
// WAIT_CALC | waiting for dp_calc_done, watchdog counting
// RELEASE   | holding dp_read_done until the engine reports ready again
module dot3_operand_feeder
    import dot3_pkg::*;
#(
    parameter int          TAG_W     = 8,
    parameter bit          CLAMP_NEG = 1'b0,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [95:0]      in_vec_a,
    input  logic [95:0]      in_vec_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             dp_ready,
    output logic             dp_data_valid,
    output logic [31:0]      dp_data,
    input  logic             dp_data_done,
    input  logic             dp_calc_done,
    input  logic [31:0]      dp_result,
    output logic             dp_read_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             o_err
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    state_t            state;
    logic              pend_valid;
    logic [95:0]       pend_a;
    logic [95:0]       pend_b;
    logic [TAG_W-1:0]  pend_tag;
    logic [95:0]       job_a;
    logic [95:0]       job_b;
    logic [TAG_W-1:0]  job_tag;
    logic [2:0]        word_idx;
    logic [WD_W-1:0]   wd_cnt;

    assign in_ready = !pend_valid;

    always_comb begin
        dp_data = 32'h0;
        case (word_idx)
            3'd0:    dp_data = job_a[31:0];
            3'd1:    dp_data = job_a[63:32];
            3'd2:    dp_data = job_a[95:64];
            3'd3:    dp_data = job_b[31:0];
            3'd4:    dp_data = job_b[63:32];
            3'd5:    dp_data = job_b[95:64];
            default: dp_data = 32'h0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= IDLE;
            pend_valid    <= 1'b0;
            pend_a        <= '0;
            pend_b        <= '0;
            pend_tag      <= '0;
            job_a         <= '0;
            job_b         <= '0;
            job_tag       <= '0;
            word_idx      <= 3'd0;
            wd_cnt        <= '0;
            dp_data_valid <= 1'b0;
            dp_read_done  <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= 32'h0;
            out_tag       <= '0;
            o_err         <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                pend_valid <= 1'b1;
                pend_a     <= in_vec_a;
                pend_b     <= in_vec_b;
                pend_tag   <= in_tag;
            end

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // Registered out_valid gates the start, so an unread result is never overwritten.
                    if (pend_valid && dp_ready && !out_valid) begin
                        job_a         <= pend_a;
                        job_b         <= pend_b;
                        job_tag       <= pend_tag;
                        pend_valid    <= 1'b0;
                        word_idx      <= 3'd0;
                        dp_data_valid <= 1'b1;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (dp_data_done) begin
                        if (word_idx == 3'd5) begin
                            dp_data_valid <= 1'b0;
                            wd_cnt        <= '0;
                            state         <= WAIT_CALC;
                        end else begin
                            word_idx <= word_idx + 3'd1;
                        end
                    end
                end
                WAIT_CALC: begin
                    if (dp_calc_done) begin
                        out_result   <= CLAMP_NEG ? fp32_clamp_neg(dp_result) : dp_result;
                        out_tag      <= job_tag;
                        out_valid    <= 1'b1;
                        dp_read_done <= 1'b1;
                        state        <= RELEASE;
                    end else begin
                        if (wd_cnt != WD_LIMIT)
                            wd_cnt <= wd_cnt + 1'b1;
                        if ((TIMEOUT != 0) && (wd_cnt == WD_LIMIT - 1'b1))
                            o_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (dp_ready) begin
                        dp_read_done <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot3_operand_feeder.sv
// Scoreboard bench: two feeders (clamp on / off) share stimulus and a behavioural engine model.
module tb_dot3_operand_feeder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [95:0] in_vec_a, in_vec_b;
    logic [7:0]  in_tag;
    logic        dp_ready, dp_data_done, dp_calc_done;
    logic [31:0] dp_result;
    logic        out_ready;

    logic        in_ready0, dp_data_valid0, dp_read_done0, out_valid0, o_err0;
    logic [31:0] dp_data0, out_result0;
    logic [7:0]  out_tag0;
    logic        in_ready1, dp_data_valid1, dp_read_done1, out_valid1, o_err1;
    logic [31:0] dp_data1, out_result1;
    logic [7:0]  out_tag1;

    dot3_operand_feeder #(.TAG_W(8), .CLAMP_NEG(1'b1), .TIMEOUT(16)) u_dut (
        .iClk(clk), .iRst(rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_tag(in_tag),
        .dp_ready(dp_ready), .dp_data_valid(dp_data_valid0), .dp_data(dp_data0), .dp_data_done(dp_data_done),
        .dp_calc_done(dp_calc_done), .dp_result(dp_result), .dp_read_done(dp_read_done0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0), .out_tag(out_tag0),
        .o_err(o_err0)
    );

    dot3_operand_feeder #(.TAG_W(8), .CLAMP_NEG(1'b0), .TIMEOUT(0)) u_dut_nc (
        .iClk(clk), .iRst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_tag(in_tag),
        .dp_ready(dp_ready), .dp_data_valid(dp_data_valid1), .dp_data(dp_data1), .dp_data_done(dp_data_done),
        .dp_calc_done(dp_calc_done), .dp_result(dp_result), .dp_read_done(dp_read_done1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1), .out_tag(out_tag1),
        .o_err(o_err1)
    );

    typedef struct {
        logic [31:0] r_clamp;
        logic [31:0] r_raw;
        logic [7:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] word_q[$];
    logic [31:0] eng_res_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h t=%0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_head();
        if (word_q.size() == 0)
            return 32'hBAD0_BAD0;
        return word_q[0];
    endfunction

    // Engine model: leaves idle one cycle after data_valid, optional stalls per word, calc after 2 cycles.
    typedef enum {E_IDLE, E_LOAD, E_CALC, E_WREAD} eng_t;
    eng_t eng_state;
    int   stall_cycles = 0;
    bit   never_calc = 1'b0;
    int   stall_cnt, nwords, calc_wait;
    int   n_handshakes = 0;

    initial begin
        logic [31:0] w;
        eng_state    = E_IDLE;
        dp_ready     = 1'b0;
        dp_data_done = 1'b0;
        dp_calc_done = 1'b0;
        dp_result    = 32'h0;
        stall_cnt    = 0;
        nwords       = 0;
        calc_wait    = 0;
        forever begin
            @(posedge clk); #1;
            dp_data_done = 1'b0;
            dp_calc_done = 1'b0;
            if (rst) begin
                eng_state = E_IDLE;
                dp_ready  = 1'b0;
                nwords    = 0;
                stall_cnt = 0;
                word_q.delete();
                eng_res_q.delete();
            end else begin
                case (eng_state)
                    E_IDLE: begin
                        dp_ready = 1'b1;
                        if (dp_data_valid0) begin
                            chk("first_word", 64'(dp_data0), 64'(word_head()));
                            nwords    = 0;
                            stall_cnt = 0;
                            eng_state = E_LOAD;
                        end
                    end
                    E_LOAD: begin
                        dp_ready = 1'b0;
                        if (!dp_data_valid0) begin
                            chk("valid_drop", 64'(dp_data_valid0), 64'h1);
                        end else if (stall_cnt < stall_cycles) begin
                            stall_cnt++;
                            chk("hold", 64'(dp_data0), 64'(word_head()));
                        end else begin
                            dp_data_done = 1'b1;
                            stall_cnt    = 0;
                            w = word_head();
                            if (word_q.size() != 0) void'(word_q.pop_front());
                            chk("word", 64'(dp_data0), 64'(w));
                            chk("word_nc", 64'(dp_data1), 64'(w));
                            nwords++;
                            if (nwords == 6) begin
                                eng_state = E_CALC;
                                calc_wait = 0;
                            end
                        end
                    end
                    E_CALC: begin
                        dp_ready = 1'b0;
                        if (dp_data_valid0)
                            chk("extra_valid", 64'(dp_data_valid0), 64'h0);
                        calc_wait++;
                        if (!never_calc && calc_wait >= 2) begin
                            dp_calc_done = 1'b1;
                            dp_result    = (eng_res_q.size() != 0) ? eng_res_q.pop_front() : 32'hDEAD_BEEF;
                            eng_state    = E_WREAD;
                        end
                    end
                    E_WREAD: begin
                        chk("read_done", 64'(dp_read_done0), 64'h1);
                        dp_ready  = 1'b1;
                        eng_state = E_IDLE;
                    end
                    default: eng_state = E_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk)
        if (!rst && dp_data_valid0 && dp_data_done)
            n_handshakes++;

    // Result sink: pops the scoreboard whenever a handshake will complete at the next edge.
    bit sink_en = 1'b1;
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = sink_en;
            if (!rst && out_valid0 && sink_en) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'h1, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'(out_result0), 64'(e.r_clamp));
                    chk("tag", 64'(out_tag0), 64'(e.tag));
                    chk("valid_nc", 64'(out_valid1), 64'h1);
                    chk("result_nc", 64'(out_result1), 64'(e.r_raw));
                    chk("tag_nc", 64'(out_tag1), 64'(e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic send_job(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                            input logic [7:0] tag, input logic [31:0] eng_res,
                            input logic [31:0] r_clamp, input logic [31:0] r_raw);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 64'h0, 64'h1);
        in_valid = 1'b1;
        in_vec_a = {a2, a1, a0};
        in_vec_b = {b2, b1, b0};
        in_tag   = tag;
        word_q.push_back(a0); word_q.push_back(a1); word_q.push_back(a2);
        word_q.push_back(b0); word_q.push_back(b1); word_q.push_back(b2);
        eng_res_q.push_back(eng_res);
        e.r_clamp = r_clamp;
        e.r_raw   = r_raw;
        e.tag     = tag;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_basic(input logic [7:0] tag, input logic [31:0] eng_res,
                              input logic [31:0] r_clamp, input logic [31:0] r_raw);
        send_job(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, tag, eng_res, r_clamp, r_raw);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || word_q.size() != 0 || eng_state != E_IDLE) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 64'h0, 64'h1);
        tick();
    endtask

    initial begin
        int n;
        int hs_start;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_vec_a = '0;
        in_vec_b = '0;
        in_tag   = '0;
        repeat (3) tick();

        chk("rst_in_ready", 64'(in_ready0), 64'h1);
        chk("rst_out_valid", 64'(out_valid0), 64'h0);
        chk("rst_dp_valid", 64'(dp_data_valid0), 64'h0);
        chk("rst_read_done", 64'(dp_read_done0), 64'h0);
        chk("rst_err", 64'(o_err0), 64'h0);
        chk("rst_result", 64'(out_result0), 64'h0);
        chk("rst_tag", 64'(out_tag0), 64'h0);
        chk("rst_in_ready_nc", 64'(in_ready1), 64'h1);
        chk("rst_dp_valid_nc", 64'(dp_data_valid1), 64'h0);
        chk("rst_read_done_nc", 64'(dp_read_done1), 64'h0);
        rst = 1'b0;
        tick();

        // (1,2,3).(4,5,6) = 32.0, plus the two-cycle accept-to-data latency.
        send_basic(8'h5A, 32'h4200_0000, 32'h4200_0000, 32'h4200_0000);
        chk("lat_cycle1", 64'(dp_data_valid0), 64'h0);
        tick();
        chk("lat_cycle2", 64'(dp_data_valid0), 64'h1);
        wait_drain();

        send_job(32'h3F80_0000, 32'h0, 32'h0, 32'hC000_0000, 32'h0, 32'h0,
                 8'h11, 32'hC000_0000, 32'h0000_0000, 32'hC000_0000);
        send_basic(8'h12, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
        send_basic(8'h13, 32'hFFC0_0001, 32'hFFC0_0001, 32'hFFC0_0001);
        send_basic(8'h14, 32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000);
        send_basic(8'h15, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        wait_drain();

        // Second job must wait for the first result to be accepted.
        sink_en = 1'b0;
        send_basic(8'h01, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        send_basic(8'h02, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000);
        repeat (40) tick();
        chk("b2b_out_valid", 64'(out_valid0), 64'h1);
        chk("b2b_out_tag", 64'(out_tag0), 64'h01);
        chk("b2b_out_result", 64'(out_result0), 64'h4000_0000);
        chk("b2b_pend_full", 64'(in_ready0), 64'h0);
        chk("b2b_not_started", 64'(dp_data_valid0), 64'h0);
        chk("b2b_words_left", 64'(word_q.size()), 64'd6);
        sink_en = 1'b1;
        wait_drain();

        stall_cycles = 3;
        hs_start = n_handshakes;
        send_basic(8'h77, 32'h4100_0000, 32'h4100_0000, 32'h4100_0000);
        wait_drain();
        chk("stall_handshakes", 64'(n_handshakes - hs_start), 64'd6);
        stall_cycles = 0;
        chk("no_err_normal", 64'(o_err0), 64'h0);

        // Watchdog: o_err rises on the 16th WAIT_CALC edge and is sticky until reset.
        never_calc = 1'b1;
        send_basic(8'h88, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        n = 0;
        while (eng_state != E_CALC && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("calc_wait_timeout", 64'h0, 64'h1);
        repeat (16) tick();
        chk("err_early", 64'(o_err0), 64'h0);
        tick();
        chk("err_set", 64'(o_err0), 64'h1);
        chk("err_disabled_nc", 64'(o_err1), 64'h0);
        repeat (20) tick();
        chk("err_sticky", 64'(o_err0), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        never_calc = 1'b0;
        exp_q.delete();
        chk("err_cleared", 64'(o_err0), 64'h0);
        tick();

        // Reset while word 3 (B0) is on the bus.
        stall_cycles = 2;
        send_basic(8'h99, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        n = 0;
        while (nwords != 3 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("word3_timeout", 64'h0, 64'h1);
        tick();
        chk("word3_on_bus", 64'(dp_data0), 64'h4080_0000);
        rst = 1'b1;
        tick();
        chk("abort_in_ready", 64'(in_ready0), 64'h1);
        chk("abort_out_valid", 64'(out_valid0), 64'h0);
        chk("abort_dp_valid", 64'(dp_data_valid0), 64'h0);
        rst = 1'b0;
        exp_q.delete();
        stall_cycles = 0;
        tick();

        send_basic(8'hC3, 32'h4200_0000, 32'h4200_0000, 32'h4200_0000);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
